// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State encodings, the NOP used as the reset instruction, and default widths.
package fetch_seq_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH  = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_BOOT = 3'd0,
    FS_REQ  = 3'd1,
    FS_WAIT = 3'd2,
    FS_HOLD = 3'd3,
`ifdef FETCH_MISALIGN_TRAP_EN
    FS_DROP = 3'd4,
    FS_HALT = 3'd5
`else
    FS_DROP = 3'd4
`endif
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch bus bundle: instruction-memory req/gnt/rvalid channel plus the valid/ready path to ID.
// master = fetch sequencer side, slave = memory/decode environment side.
interface fetch_seq_if
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = 32
);

  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output inst_valid_o,
    output inst_o,
    output inst_pc_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  inst_valid_o,
    input  inst_o,
    input  inst_pc_o,
    output inst_ready_i
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC selection: hold, sequential +4, or redirect target.
// Bits [1:0] are masked on every load, so the PC is word aligned by construction.
module fetch_pc_reg
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W    = INST_ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  // Redirect wins over increment; the increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= BOOT_ADDR & ALIGN_MASK;
    end else if (load) begin
      pc <= load_addr & ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: FSM, ID output register and stale-response drop logic.
// Define FETCH_MISALIGN_TRAP_EN to add misalign_o and the HALT state for misaligned redirects.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W    = INST_ADDR_WIDTH,
  parameter int                INST_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  fetch_seq_if.master       bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;

  logic slot_free;
  logic req;
  logic granted;
  logic redirect_take;
  logic pc_inc;
  logic pc_load;
  logic pending_base;
  logic pending_next;

  // A request is only presented when its eventual response has a free slot to land in.
  assign slot_free     = !inst_valid_q || bus.inst_ready_i;
  assign req           = (state == FS_REQ) && slot_free;
  assign granted       = req && bus.imem_gnt_i;
  assign redirect_take = redirect_i && (state != FS_BOOT);
  assign pc_inc        = (state == FS_WAIT) && bus.imem_rvalid_i && !redirect_take;

  // Whether a granted request will still owe us a response after this cycle.
  assign pending_base = ((state == FS_WAIT) && !bus.imem_rvalid_i) || granted ||
                        ((state == FS_DROP) && !bus.imem_rvalid_i);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  logic halt_pending;
  logic target_misaligned;

  assign target_misaligned = is_misaligned(redirect_addr_i[1:0]);
  assign pc_load           = redirect_take && !target_misaligned;
  assign pending_next      = pending_base ||
                             ((state == FS_HALT) && halt_pending && !bus.imem_rvalid_i);
  assign misalign_o        = misalign_q;
`else
  assign pc_load      = redirect_take;
  assign pending_next = pending_base;
`endif

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .BOOT_ADDR(BOOT_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_addr(redirect_addr_i),
    .pc       (pc)
  );

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = pc;
  assign bus.inst_valid_o = inst_valid_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;

  // A redirect during DROP that coincides with the stale rvalid has nothing left to drop,
  // so it goes straight to REQ instead of waiting for a response that will never come.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FS_BOOT;
      inst_valid_q <= 1'b0;
      inst_q       <= INST_W'(NOP_INST);
      inst_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
      halt_pending <= 1'b0;
`endif
    end else begin
      if (inst_valid_q && bus.inst_ready_i) begin
        inst_valid_q <= 1'b0;
      end
      if (redirect_take) begin
        inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target_misaligned) begin
          misalign_q   <= 1'b1;
          halt_pending <= pending_next;
          state        <= FS_HALT;
        end else begin
          misalign_q   <= 1'b0;
          halt_pending <= 1'b0;
          state        <= pending_next ? FS_DROP : FS_REQ;
        end
`else
        state <= pending_next ? FS_DROP : FS_REQ;
`endif
      end else begin
        case (state)
          FS_BOOT: state <= FS_REQ;
          FS_REQ: begin
            if (granted) begin
              state <= FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (bus.imem_rvalid_i) begin
              inst_q       <= bus.imem_rdata_i;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              state        <= bus.inst_ready_i ? FS_REQ : FS_HOLD;
            end
          end
          FS_HOLD: begin
            if (bus.inst_ready_i) begin
              state <= FS_REQ;
            end
          end
          FS_DROP: begin
            if (bus.imem_rvalid_i) begin
              state <= FS_REQ;
            end
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          FS_HALT: begin
            if (bus.imem_rvalid_i) begin
              halt_pending <= 1'b0;
            end
          end
`endif
          default: state <= FS_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: random memory timing, ID backpressure and redirects,
// checked against a program-order model of which (pc, instruction) pairs ID may receive.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  fetch_seq_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  fetch_seq #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .BOOT_ADDR(32'h0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_o     (misalign),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } mem_req_t;
  typedef struct { int c; logic [31:0] addr; } req_rec_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  mem_req_t    mem_q[$];
  req_rec_t    req_log[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          accepted = 0;
  int          first_valid_cyc = -1;
  bit          mon_en = 1'b0;
  bit          halted = 1'b0;
  bit          exp_mis = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_redirect = 1'b0;
  logic [31:0] prev_inst = 32'h0;
  logic [31:0] prev_pc = 32'h0;

  // Instruction memory contents: a bijection of the address, with the decode-test word at 0x4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_state();
    check_output("rst_req", bus.imem_req_o, 0);
    check_output("rst_valid", bus.inst_valid_o, 0);
    check_output("rst_inst", bus.inst_o, 32'h0000_0013);
    check_output("rst_inst_pc", bus.inst_pc_o, 0);
    check_output("rst_addr", bus.imem_addr_o, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_output("rst_misalign", misalign, 0);
`endif
  endtask

  task automatic model_restart();
    mem_q.delete();
    req_log.delete();
    exp_q.delete();
    exp_pc          = 32'h0;
    halted          = 1'b0;
    exp_mis         = 1'b0;
    prev_valid      = 1'b0;
    first_valid_cyc = -1;
    cyc             = 0;
  endtask

  // One clock of stimulus: ID ready, redirect, grant, and the memory's in-order responses.
  task automatic apply_stimulus(input bit rnd, input bit rdy, input bit redir, input logic [31:0] tgt);
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    redirect      = redir;
    redirect_addr = tgt;
    if (rnd) begin
      bus.inst_ready_i = ($urandom_range(0, 3) != 0);
      bus.imem_gnt_i   = ($urandom_range(0, 9) < 7);
      lat              = $urandom_range(1, 3);
    end else begin
      bus.inst_ready_i = rdy;
      bus.imem_gnt_i   = 1'b1;
      lat              = 1;
    end
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
    if (bus.imem_req_o) req_log.push_back('{cyc, bus.imem_addr_o});
    if (bus.imem_req_o && bus.imem_gnt_i) begin
      check_output("one_outstanding", mem_q.size(), 0);
      due = cyc + lat;
      if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
      mem_q.push_back('{due, bus.imem_addr_o});
    end
  endtask

  // Monitor: ID handshakes are popped from the expected program-order queue.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (prev_valid && !prev_ready && !prev_redirect) begin
        check_output("hold_valid", bus.inst_valid_o, 1);
        check_output("hold_inst", bus.inst_o, prev_inst);
        check_output("hold_pc", bus.inst_pc_o, prev_pc);
      end
      if (bus.imem_req_o) begin
        check_output("addr_align", bus.imem_addr_o[1:0], 0);
        check_output("req_while_full", bus.inst_valid_o && !bus.inst_ready_i, 0);
      end
      if (bus.inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.inst_valid_o && bus.inst_ready_i) begin
        accepted++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_inst actual pc=0x%0h inst=0x%0h expected none (cycle %0d)",
                   bus.inst_pc_o, bus.inst_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("inst_pc", bus.inst_pc_o, e.pc);
          check_output("inst_data", bus.inst_o, e.inst);
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check_output("misalign", misalign, exp_mis);
`endif
      if (redirect) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_addr[1:0] != 2'b00) begin
          halted  = 1'b1;
          exp_mis = 1'b1;
        end else begin
          halted  = 1'b0;
          exp_mis = 1'b0;
          exp_pc  = redirect_addr;
        end
`else
        exp_pc = redirect_addr & ~32'h3;
`endif
      end
      if (!halted && exp_q.size() == 0) begin
        exp_q.push_back('{exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'h4;
      end
      prev_valid    = bus.inst_valid_o;
      prev_ready    = bus.inst_ready_i;
      prev_redirect = redirect;
      prev_inst     = bus.inst_o;
      prev_pc       = bus.inst_pc_o;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int acc0;
    reset_n           = 1'b0;
    redirect          = 1'b0;
    redirect_addr     = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.inst_ready_i  = 1'b0;
    model_restart();
    repeat (3) @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    #1;
    check_output("boot_idle_req", bus.imem_req_o, 0);

    // Streaming with single-cycle memory: requests every other cycle at 0x0, 0x4, 0x8.
    repeat (6) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    if (req_log.size() < 3) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL stream_reqs actual=%0d requests expected=3", req_log.size());
    end else begin
      check_output("first_req_cycle", req_log[0].c, 1);
      check_output("req0_addr", req_log[0].addr, 32'h0);
      check_output("req1_cycle", req_log[1].c, 3);
      check_output("req1_addr", req_log[1].addr, 32'h4);
      check_output("req2_cycle", req_log[2].c, 5);
      check_output("req2_addr", req_log[2].addr, 32'h8);
    end
    check_output("first_valid_cycle", first_valid_cyc, 3);

    // ID stalls: the presented instruction must hold and no new fetch may start.
    repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

    acc0 = accepted;
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      logic [31:0] t;
      r = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 1023));
`ifdef FETCH_MISALIGN_TRAP_EN
      t[1:0] = 2'b00;
`endif
      apply_stimulus(1'b1, 1'b0, r, t);
    end
    check_output("random_progress", (accepted - acc0) >= 100, 1);

    // Reset mid-operation aborts everything, asynchronously.
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    check_reset_state();
    redirect          = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.inst_ready_i  = 1'b1;
    model_restart();
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Top-of-address-space fetch wraps to 0.
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    req_log.delete();
    repeat (8) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    if (req_log.size() < 2) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wrap_reqs actual=%0d requests expected=2", req_log.size());
    end else begin
      check_output("wrap_req0", req_log[0].addr, 32'hFFFF_FFFC);
      check_output("wrap_req1", req_log[1].addr, 32'h0);
    end

    // Misaligned redirect target.
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h102);
    req_log.delete();
    repeat (8) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_output("halt_no_req", req_log.size(), 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h200);
    req_log.delete();
    repeat (8) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    if (req_log.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unhalt_req actual=none expected=0x200");
    end else begin
      check_output("unhalt_req", req_log[0].addr, 32'h200);
    end
`else
    if (req_log.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL masked_req actual=none expected=0x100");
    end else begin
      check_output("masked_req", req_log[0].addr, 32'h100);
    end
`endif

    $display("[TB] accepted %0d instructions", accepted);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
